// File: rtl/flit_rx_vc_buffer.sv
// ============================================================================
// Module   : flit_rx_vc_buffer
// Function : receive-side flit buffer with one FIFO per virtual channel,
//            fixed-priority merge (highest non-empty VC) onto one output stream.
//            Optional feature macro: RX_OVF_CHECK_EN (sticky overflow flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_rx_vc_buffer #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3,
  parameter int BUFF_DEPTH = 4,
  localparam int VCW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  fin_valid,
  input  logic [VCW-1:0]        fin_vc_id,
  input  logic [FLIT_WIDTH-1:0] fin_data,
  output logic [N_VIRT_CHN-1:0] fin_ready,
  output logic                  fout_valid,
  output logic [VCW-1:0]        fout_vc_id,
  output logic [FLIT_WIDTH-1:0] fout_data,
  input  logic                  fout_ready,
  output logic                  err_ovf
);

  localparam int c_PTR_W = (BUFF_DEPTH > 1) ? $clog2(BUFF_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(BUFF_DEPTH + 1);

  logic [N_VIRT_CHN-1:0] w_nonempty;
  logic [N_VIRT_CHN-1:0] w_push;
  logic [N_VIRT_CHN-1:0] w_pop;
  logic [FLIT_WIDTH-1:0] w_head [N_VIRT_CHN];
  logic [VCW-1:0]        w_sel;
  logic                  w_vc_legal;

  // Non-power-of-two VC counts leave encodings that address no FIFO.
  assign w_vc_legal = (int'(fin_vc_id) < N_VIRT_CHN);

  for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
    logic [FLIT_WIDTH-1:0] r_mem [BUFF_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    // Ready depends only on the registered count, never on fout_ready.
    assign fin_ready[v]  = (r_count != c_CNT_W'(BUFF_DEPTH));
    assign w_nonempty[v] = (r_count != '0);
    assign w_push[v]     = fin_valid && w_vc_legal && (fin_vc_id == VCW'(v)) && fin_ready[v];
    assign w_pop[v]      = fout_valid && fout_ready && (w_sel == VCW'(v));
    assign w_head[v]     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[v]) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop[v]) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage carries no reset; stale entries are never visible because
    // the output is gated by the per-VC count.
    always_ff @(posedge clk) begin
      if (w_push[v]) begin
        r_mem[r_wr_ptr] <= fin_data;
      end
    end
  end

  // Later iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    w_sel = '0;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (w_nonempty[v]) begin
        w_sel = VCW'(v);
      end
    end
  end

  assign fout_valid = |w_nonempty;
  assign fout_vc_id = fout_valid ? w_sel : '0;
  assign fout_data  = fout_valid ? w_head[w_sel] : '0;

`ifdef RX_OVF_CHECK_EN
  logic w_ovf_evt;
  logic r_err_ovf;

  // Any offered flit that is not accepted is either a full-VC push or an
  // illegal VC id; both count as overflow.
  assign w_ovf_evt = fin_valid && !(|w_push);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_err_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_err_ovf <= 1'b1;
      $error("flit_rx_vc_buffer: overflow or illegal VC push (vc=%0d)", fin_vc_id);
    end
  end

  assign err_ovf = r_err_ovf;
`else
  assign err_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/flit_rx_vc_buffer.md
# flit_rx_vc_buffer

Receiving end of the router flit link: it accepts flits from an upstream sender on the flit request/response handshake and stores them in one FIFO per virtual channel. Per-VC ready is returned to the sender as backpressure. A single merged output stream is presented to the router's routing/crossbar stage, with fixed priority given to the highest non-empty VC. It sits at every router input port, and at the NI-to-router boundary, as the counterpart to a `send_flit` driver.

## Interface

Parameters:
- `FLIT_WIDTH`, 34: flit payload width in bits, including type bits.
- `N_VIRT_CHN`, 3: number of virtual channels; must be ≥1.
- `BUFF_DEPTH`, 4: flits per VC FIFO; must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `arst`, input, 1: asynchronous, active-low reset.
- `fin_valid`, input, 1: sender presents a flit.
- `fin_vc_id`, input, `$clog2(N_VIRT_CHN)` (min 1): target VC of the incoming flit.
- `fin_data`, input, `FLIT_WIDTH`: incoming flit.
- `fin_ready`, output, `N_VIRT_CHN`: per-VC ready; bit v = VC v can accept.
- `fout_valid`, output, 1: a buffered flit is presented downstream.
- `fout_vc_id`, output, `$clog2(N_VIRT_CHN)` (min 1): VC of the presented flit.
- `fout_data`, output, `FLIT_WIDTH`: presented flit.
- `fout_ready`, input, 1: downstream accepts the presented flit.
- `err_ovf`, output, 1: sticky overflow flag (see Configuration).

## Operation

- Per VC v: circular FIFO with `wr_ptr`, `rd_ptr` (`$clog2(BUFF_DEPTH)` bits, natural wrap) and `count` (`$clog2(BUFF_DEPTH+1)` bits).
- `fin_ready[v] = (count[v] != BUFF_DEPTH)`. Derived only from registered state, with no combinational path from `fout_ready`.
- Push to VC v: `fin_valid && fin_vc_id==v && fin_ready[v]`. Writes `fin_data` at `wr_ptr[v]`, then `wr_ptr++` and `count++`.
- Push to a VC whose ready is low is an illegal overflow. The flit is discarded, no state changes, and the event is handled per Configuration.
- `fin_vc_id >= N_VIRT_CHN` with `fin_valid`: flit discarded; treated as an overflow event.
- Arbitration: selected VC = highest index with `count != 0`. `fout_valid = |(count != 0)`. `fout_vc_id` and `fout_data` are the selected index and the head entry of that VC.
- Pop: `fout_valid && fout_ready` gives `rd_ptr[sel]++` and `count[sel]--`.
- Priority is re-evaluated every cycle with no packet locking. Ordering is preserved within a VC only.
- Push and pop on the same VC in the same cycle: both take effect and `count` is unchanged. This is only possible when not full.
- When `fout_valid` is 0, `fout_vc_id` and `fout_data` are 0.

## Timing

- Reset (`arst` low, asynchronous):
  - all pointers and counts = 0
  - `fin_ready` = all ones
  - `fout_valid` = 0, `fout_vc_id` = 0, `fout_data` = 0
  - `err_ovf` = 0
- Reset mid-operation: all buffered flits are lost immediately. Reset release is synchronous to `clk`.
- Latency: a flit pushed at edge N is visible on `fout_*` after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- `fin_ready[v]` deasserts in the cycle after the push that fills VC v. It reasserts in the cycle after the first pop from a full VC.
- Full throughput: one push and one pop per cycle, sustained.
- `fout_*` is stable while `fout_valid && !fout_ready`, unless a higher VC receives a flit. In that case the selection switches; downstream must not assume stability.

## Configuration

- `RX_OVF_CHECK_EN` defined:
  - `err_ovf` sets on any overflow or illegal-VC event at the next edge.
  - It stays set until reset.
  - A simulation-only `$error` is also emitted on the event.
- `RX_OVF_CHECK_EN` undefined:
  - `err_ovf` is tied to 0.
  - Illegal pushes are silently dropped.
  - No overflow logic is synthesized.

## Test plan

- Reset, then push `0x1` on VC0 in cycle 1 with `fout_ready`=1: `fout_valid`=1, `fout_vc_id`=0, `fout_data`=`0x1` in cycle 2. Buffer is empty in cycle 3.
- Fill VC1 with 4 flits `0xA..0xD` while `fout_ready`=0: `fin_ready`=`3'b101` after the 4th push. Draining yields `0xA,0xB,0xC,0xD` in order, and `fin_ready[1]` returns to 1 the cycle after the first pop.
- Load VC0 with `0x10` and VC2 with `0x20`, then assert `fout_ready`: `0x20` (VC2) is output before `0x10` (VC0).
- VC0 holds 2 flits; push and pop on VC0 every cycle for 10 cycles: count stays 2, no bubbles, data is FIFO-ordered.
- With VC2 full, push `0xFF` to VC2 with `RX_OVF_CHECK_EN` set: the flit is dropped, VC2 contents are unchanged, `err_ovf`=1 from the next cycle until reset. Without the macro, `err_ovf` stays 0.
- Assert `arst` low mid-stream with 3 flits buffered: `fout_valid`=0 and `fin_ready`=all ones immediately, and nothing is output after release.
